// File: rtl/bcd_a_binario_if.sv
// Digit-entry bus for bcd_a_binario.
// gray exists only when GRAY_SALIDA_EN is defined.
interface bcd_a_binario_if;
  logic [3:0] digito_in;
  logic       digito_valido;
  logic [3:0] bin;
  logic       bin_valido;
  logic       error;
  logic       ocupado;
`ifdef GRAY_SALIDA_EN
  logic [3:0] gray;
`endif

  modport master (
    output digito_in,
    output digito_valido,
    input  bin,
    input  bin_valido,
    input  error,
    input  ocupado
`ifdef GRAY_SALIDA_EN
    ,
    input  gray
`endif
  );

  modport slave (
    input  digito_in,
    input  digito_valido,
    output bin,
    output bin_valido,
    output error,
    output ocupado
`ifdef GRAY_SALIDA_EN
    ,
    output gray
`endif
  );
endinterface

// File: rtl/bcd_a_binario.sv
// Serial tens/units BCD capture rebuilding a 4-bit binary value.
// Optional registered Gray output enabled by GRAY_SALIDA_EN.
module bcd_a_binario #(
  parameter int TIMEOUT = 10000,
  parameter int MAX_VAL = 15
) (
  input logic            clk,
  input logic            rst,
  bcd_a_binario_if.slave bus
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [6:0] V_MAX = 7'(MAX_VAL);

  typedef enum logic {
    ESPERA_DECENAS,
    ESPERA_UNIDADES
  } estado_t;

  estado_t       estado;
  logic [3:0]    decenas;
  logic [TW-1:0] timer;
  logic [6:0]    valor;
  logic          dig_ok;

  // 7 bits hold up to 99, so no overflow for any valid digit pair
  always_comb begin
    valor  = ({3'b000, decenas} * 7'd10) + {3'b000, bus.digito_in};
    dig_ok = (bus.digito_in <= 4'd9);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado         <= ESPERA_DECENAS;
      decenas        <= '0;
      timer          <= '0;
      bus.bin        <= '0;
      bus.bin_valido <= 1'b0;
      bus.error      <= 1'b0;
      bus.ocupado    <= 1'b0;
`ifdef GRAY_SALIDA_EN
      bus.gray       <= '0;
`endif
    end else begin
      bus.bin_valido <= 1'b0;
      bus.error      <= 1'b0;
      unique case (estado)
        ESPERA_DECENAS: begin
          if (bus.digito_valido) begin
            if (!dig_ok) begin
              bus.error <= 1'b1;
            end else begin
              decenas     <= bus.digito_in;
              timer       <= '0;
              estado      <= ESPERA_UNIDADES;
              bus.ocupado <= 1'b1;
            end
          end
        end
        ESPERA_UNIDADES: begin
          // a strobe on the expiry cycle takes priority over the timeout
          if (bus.digito_valido) begin
            estado      <= ESPERA_DECENAS;
            bus.ocupado <= 1'b0;
            if (!dig_ok || valor > V_MAX) begin
              bus.error <= 1'b1;
            end else begin
              bus.bin        <= valor[3:0];
              bus.bin_valido <= 1'b1;
`ifdef GRAY_SALIDA_EN
              bus.gray       <= valor[3:0] ^ (valor[3:0] >> 1);
`endif
            end
          end else if (timer == T_LAST) begin
            bus.error   <= 1'b1;
            decenas     <= '0;
            estado      <= ESPERA_DECENAS;
            bus.ocupado <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: estado <= ESPERA_DECENAS;
      endcase
    end
  end
endmodule
